// File: rtl/iob_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the IOb native bus.
// One transaction in flight; read data is routed back to the issuing master.
module iob_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_avalid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_avalid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_avalid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic [1:0]          grant,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_owner, w_owner_nxt;
    logic                r_last,  w_last_nxt;

    logic                w_av;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_wstrb;

    assign w_av    = r_owner ? m1_avalid : m0_avalid;
    assign w_addr  = r_owner ? m1_addr   : m0_addr;
    assign w_wdata = r_owner ? m1_wdata  : m0_wdata;
    assign w_wstrb = r_owner ? m1_wstrb  : m0_wstrb;

    // Read data is broadcast; only rvalid carries ownership.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        s_avalid    = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        grant       = 2'b00;

        case (r_state)
            IDLE: begin
                if (m0_avalid || m1_avalid) begin
                    w_state_nxt = REQ;
                    // On a tie the master not served last wins.
                    w_owner_nxt = (m0_avalid && m1_avalid) ? ~r_last : m1_avalid;
                end
            end
            REQ: begin
                grant    = {r_owner, ~r_owner};
                s_avalid = w_av;
                s_addr   = w_addr;
                s_wdata  = w_wdata;
                s_wstrb  = w_wstrb;
                m0_ready = ~r_owner & s_ready;
                m1_ready =  r_owner & s_ready;
                if (!w_av) begin
                    w_state_nxt = IDLE;
                end else if (s_ready) begin
                    w_last_nxt  = r_owner;
                    w_state_nxt = (w_wstrb != '0) ? IDLE : RDATA;
                end
            end
            RDATA: begin
                grant     = {r_owner, ~r_owner};
                m0_rvalid = ~r_owner & s_rvalid;
                m1_rvalid =  r_owner & s_rvalid;
                if (s_rvalid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
